qbert_cube_level_map: RTL

//  Parametrised pyramid cube-colour engine: owns the colour level of every top face.

---
 rtl/qbert_cube_level_map_pkg.sv | 54 +++++
 rtl/qbert_cube_level_map_cube_top_hit.sv | 40 ++++
 rtl/qbert_cube_level_map.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/qbert_cube_level_map_pkg.sv
// Shared types and helpers for the Q*bert pyramid colour map: FSM states, landing rules,
// cube numbering (rank-major) and the per-landing level update rule.
package qbert_map_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        PLAY     = 2'd2,
        COMPLETE = 2'd3
    } map_state_t;

    typedef enum logic [1:0] {
        STEP_STAY     = 2'd0,
        TOGGLE        = 2'd1,
        STEP_WRAP     = 2'd2,
        STEP_STAY_ALT = 2'd3
    } land_mode_t;

    // Widest level code supported (N_LEVEL up to 8).
    localparam int MAX_LW = 3;

    // Number of cubes in a pyramid of r ranks; also the index of the first cube of rank r.
    function automatic int n_cube(input int r);
        return r * (r + 1) / 2;
    endfunction

    // Rank/column lookup for a rank-major cube index, evaluated at elaboration.
    function automatic int rank_of(input int idx);
        int rank;
        rank = 0;
        for (int r = 1; r < 64; r++) begin
            if (idx >= n_cube(r)) rank = r;
        end
        return rank;
    endfunction

    function automatic int col_of(input int idx);
        return idx - n_cube(rank_of(idx));
    endfunction

    // Level after one landing; top is the target level N_LEVEL-1.
    function automatic logic [MAX_LW-1:0] next_level(input logic [MAX_LW-1:0] lvl,
                                                     input land_mode_t      mode,
                                                     input logic [MAX_LW-1:0] top);
        logic [MAX_LW-1:0] nl;
        case (mode)
            TOGGLE:    nl = (lvl == top) ? lvl - 3'd1 : lvl + 3'd1;
            STEP_WRAP: nl = (lvl == top) ? 3'd0 : lvl + 3'd1;
            default:   nl = (lvl >= top) ? top : lvl + 3'd1;
        endcase
        return nl;
    endfunction

endpackage

// File: rtl/qbert_cube_level_map_cube_top_hit.sv
// Screen-space hit test for the top face of one pyramid cube at a fixed (rank, column);
// the hit bit is registered to form stage 1 of the pixel pipe.
module cube_top_hit #(
    parameter int RANK = 0,
    parameter int COL  = 0
) (
    input  logic        CLK_33,
    input  logic        reset,
    input  logic [10:0] XLENGTH,
    input  logic [20:0] XYDIAG_DEMI,
    input  logic [20:0] RANK1_XY_OFFSET,
    input  logic [10:0] x_cnt,
    input  logic [9:0]  y_cnt,
    output logic        hit
);

    int   x_r;
    int   y_rc;
    int   xd;
    int   yd;
    logic hit_next;

    // NOTE: every variable assigned in always_comb gets a value on all paths, so no latch is inferred.
    always_comb begin
        xd   = int'(XYDIAG_DEMI[20:10]);
        yd   = int'(XYDIAG_DEMI[9:0]);
        x_r  = int'(RANK1_XY_OFFSET[20:10]) + RANK * (xd + int'(XLENGTH));
        // Row origin wraps modulo the 10-bit vertical scan range.
        y_rc = (int'(RANK1_XY_OFFSET[9:0]) + (2 * COL - RANK) * yd) & 1023;
        hit_next = (int'(x_cnt) >= x_r - xd) && (int'(x_cnt) <= x_r + xd) &&
                   (int'(y_cnt) >= y_rc)     && (int'(y_cnt) <= y_rc + 2 * yd);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK_33 or negedge reset) begin
        if (!reset) hit <= 1'b0;
        else        hit <= hit_next;
    end

endmodule

// File: rtl/qbert_cube_level_map.sv
// Pyramid cube-colour engine: per-cube level register file, landing rules, NIOS overrides,
// clear sweep, completion detection and a 2-cycle per-pixel cube-top hit pipe.
module qbert_cube_level_map
    import qbert_map_pkg::*;
#(
    parameter  int N_RANK  = 7,
    parameter  int N_LEVEL = 2,
    localparam int N_CUBE  = n_cube(N_RANK),
    localparam int LW      = $clog2(N_LEVEL),
    localparam int IW      = $clog2(N_CUBE)
) (
    input  logic                 CLK_33,
    input  logic                 reset,
    input  logic                 e_start,
    input  logic                 e_clear,
    input  logic [1:0]           e_mode,
    input  logic                 e_freeze,
    input  logic                 land_valid,
    input  logic [IW-1:0]        land_idx,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic [LW-1:0]        wr_level,
    input  logic [10:0]          XLENGTH,
    input  logic [20:0]          XYDIAG_DEMI,
    input  logic [20:0]          RANK1_XY_OFFSET,
    input  logic [10:0]          x_cnt,
    input  logic [9:0]           y_cnt,
    output logic [N_CUBE*LW-1:0] level_flat,
    output logic [IW:0]          done_cnt,
    output logic                 map_complete,
    output logic                 level_done,
    output logic                 busy,
    output logic                 pix_hit,
    output logic [LW-1:0]        pix_level
);

    localparam logic [IW:0]   CUBE_COUNT  = (IW+1)'(N_CUBE);
    localparam logic [IW-1:0] LAST_IDX    = IW'(N_CUBE - 1);
    localparam logic [LW:0]   LEVEL_COUNT = (LW+1)'(N_LEVEL);
    localparam logic [LW-1:0] TARGET      = LW'(N_LEVEL - 1);

    map_state_t        state;
    map_state_t        state_next;
    logic [IW-1:0]     clr_idx;
    logic              clr_restart;
    logic [LW-1:0]     levels [N_CUBE];
    logic              land_ok;
    logic              wr_ok;
    logic [LW-1:0]     land_result;
    logic [IW:0]       target_cnt;
    logic [N_CUBE-1:0] hit_vec;
    logic              hit_any;
    logic [IW-1:0]     hit_idx;

    // ---------------- control FSM ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (e_start) state_next = CLEAR;
            CLEAR:    if (clr_idx == LAST_IDX) state_next = PLAY;
            PLAY:     if (done_cnt == CUBE_COUNT) state_next = COMPLETE;
            COMPLETE: if (e_start) state_next = CLEAR;
            default:  state_next = IDLE;
        endcase
        if (e_clear) state_next = CLEAR;
    end

    // A clear request always restarts the sweep from cube 0, even mid-sweep.
    assign clr_restart = e_clear || (state != CLEAR && state_next == CLEAR);

    always_ff @(posedge CLK_33 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clr_idx    <= '0;
            done_cnt   <= '0;
            level_done <= 1'b0;
        end else begin
            state      <= state_next;
            done_cnt   <= target_cnt;
            level_done <= (state != COMPLETE) && (state_next == COMPLETE);
            if (clr_restart)         clr_idx <= '0;
            else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
        end
    end

    assign busy         = (state == CLEAR);
    assign map_complete = (state == COMPLETE);

    // ---------------- level register file ----------------
    assign land_ok = (state == PLAY) && land_valid && !e_freeze && ({1'b0, land_idx} < CUBE_COUNT);
    assign wr_ok   = wr_en && (state != CLEAR) && ({1'b0, wr_idx} < CUBE_COUNT) &&
                     ({1'b0, wr_level} < LEVEL_COUNT);
    assign land_result = LW'(next_level(MAX_LW'(levels[land_idx]), land_mode_t'(e_mode),
                                        MAX_LW'(TARGET)));

    // NOTE: the level file is a small flop array, not a RAM, so it is reset like any other state.
    always_ff @(posedge CLK_33 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CUBE; i++) levels[i] <= '0;
        end else begin
            if (state == CLEAR) levels[clr_idx] <= '0;
            if (land_ok)        levels[land_idx] <= land_result;
            // Later assignment wins: an override beats a landing on the same cube.
            if (wr_ok)          levels[wr_idx] <= wr_level;
        end
    end

    always_comb begin
        target_cnt = '0;
        for (int i = 0; i < N_CUBE; i++) begin
            if (levels[i] == TARGET) target_cnt = target_cnt + (IW+1)'(1);
        end
    end

    // ---------------- per-cube geometry, pixel stage 1 ----------------
    for (genvar i = 0; i < N_CUBE; i++) begin : g_cube
        assign level_flat[i*LW +: LW] = levels[i];

        cube_top_hit #(
            .RANK (rank_of(i)),
            .COL  (col_of(i))
        ) u_hit (
            .CLK_33          (CLK_33),
            .reset           (reset),
            .XLENGTH         (XLENGTH),
            .XYDIAG_DEMI     (XYDIAG_DEMI),
            .RANK1_XY_OFFSET (RANK1_XY_OFFSET),
            .x_cnt           (x_cnt),
            .y_cnt           (y_cnt),
            .hit             (hit_vec[i])
        );
    end

    // ---------------- pixel stage 2: lowest-index hit wins ----------------
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_CUBE - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge CLK_33 or negedge reset) begin
        if (!reset) begin
            pix_hit   <= 1'b0;
            pix_level <= '0;
        end else begin
            pix_hit   <= hit_any;
            pix_level <= hit_any ? levels[hit_idx] : '0;
        end
    end

endmodule
